// File: rtl/hamming_encoder_seq.sv
// Sequential Hamming encoder: one parity bit per clock over a valid/ready handshake.
// Define HAMMING_SECDED_EN to add the overall-parity (SECDED) cycle at code_o[0].

package hamming_pkg;
  // Smallest r with 2**r - r - 1 >= data_width.
  function automatic int calc_addr_width(input int data_width);
    int r;
    r = 1;
    while (((1 << r) - r - 1) < data_width) r++;
    return r;
  endfunction
endpackage

// Scatters data bits into non-power-of-two positions and pad bits into slot 0 and 2**i.
module hamming_pad #(
  parameter  int DATA_WIDTH  = 32,
  localparam int ADDR_WIDTH  = hamming_pkg::calc_addr_width(DATA_WIDTH),
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [ADDR_WIDTH:0]    pad_i,
  output logic [CODED_WIDTH-1:0] word_o
);
  for (genvar j = 0; j < CODED_WIDTH; j++) begin : g_pos
    if (j == 0) begin : g_opar
      assign word_o[j] = pad_i[0];
    end else if ((j & (j - 1)) == 0) begin : g_par
      assign word_o[j] = pad_i[$clog2(j) + 1];
    end else begin : g_data
      // Data index = position minus slot 0 minus the parity slots below it.
      assign word_o[j] = data_i[j - 1 - $clog2(j + 1)];
    end
  end
endmodule

module hamming_encoder_seq #(
  parameter  int DATA_WIDTH  = 32,
  localparam int ADDR_WIDTH  = hamming_pkg::calc_addr_width(DATA_WIDTH),
  localparam int CODE_BITS   = ADDR_WIDTH + 1,
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1,
  localparam int CNT_WIDTH   = $clog2(ADDR_WIDTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CODED_WIDTH-1:0] code_o,
  output logic                   busy_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
`ifdef HAMMING_SECDED_EN
    S_OPAR = 2'd2,
`endif
    S_OUT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_next;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]  r_par, w_par_next;
  logic [CODED_WIDTH-1:0] r_code, w_word, w_final;
  logic [CODE_BITS-1:0]   w_pad_final;
  logic                   w_par_bit, w_opar, w_last;

  assign w_last = (r_cnt == CNT_WIDTH'(ADDR_WIDTH - 1));

  hamming_pad #(.DATA_WIDTH(DATA_WIDTH)) u_pad_zero (
    .data_i (r_data),
    .pad_i  ('0),
    .word_o (w_word)
  );

  // Parity k covers every position whose index has bit k set; slot 0 never contributes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_par_bit = 1'b0;
    for (int j = 0; j < CODED_WIDTH; j++)
      if (((j >> r_cnt) & 1) != 0) w_par_bit = w_par_bit ^ w_word[j];
  end

  // Fold the bit computed this cycle in, so the final word on OUT entry is complete.
  always_comb begin
    w_par_next = r_par;
    if (r_state == S_CALC)
      for (int k = 0; k < ADDR_WIDTH; k++)
        if (r_cnt == CNT_WIDTH'(k)) w_par_next[k] = w_par_bit;
  end

`ifdef HAMMING_SECDED_EN
  // The zero-padded word has empty parity slots, so its XOR plus the parity XOR equals ^f[CW-1:1].
  assign w_opar = (^w_word[CODED_WIDTH-1:1]) ^ (^r_par);
`else
  assign w_opar = 1'b0;
`endif

  assign w_pad_final = {w_par_next, w_opar};

  hamming_pad #(.DATA_WIDTH(DATA_WIDTH)) u_pad_final (
    .data_i (r_data),
    .pad_i  (w_pad_final),
    .word_o (w_final)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (valid_i) w_state_next = S_CALC;
`ifdef HAMMING_SECDED_EN
      S_CALC: if (w_last) w_state_next = S_OPAR;
      S_OPAR: w_state_next = S_OUT;
`else
      S_CALC: if (w_last) w_state_next = S_OUT;
`endif
      S_OUT:  if (ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = rst_ni && (r_state == S_IDLE);
    busy_o  = (r_state != S_IDLE);
    valid_o = (r_state == S_OUT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_par  <= '0;
      r_code <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (valid_i) begin
          r_data <= data_i;
          r_cnt  <= '0;
          r_par  <= '0;
        end
        S_CALC: begin
          r_par <= w_par_next;
          if (w_last) begin
`ifndef HAMMING_SECDED_EN
            r_code <= w_final;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef HAMMING_SECDED_EN
        S_OPAR: r_code <= w_final;
`endif
        default: ;
      endcase
    end
  end

  assign code_o = r_code;
endmodule

// File: tb/tb_hamming_encoder_seq.sv
// Self-checking bench for hamming_encoder_seq at DATA_WIDTH=4 (8-bit code word).
// Directed table, backpressure and abort sequences, then randomized traffic against a syndrome-based model.
`timescale 1ns/1ps
module tb_hamming_encoder_seq;
  localparam int DW = 4;
  localparam int AW = 3;
  localparam int CW = 8;
`ifdef HAMMING_SECDED_EN
  localparam bit SECDED = 1'b1;
`else
  localparam bit SECDED = 1'b0;
`endif
  localparam int LAT    = SECDED ? AW + 1 : AW;
  localparam int N_RAND = 1000;
  localparam int LIMIT  = 30000;

  logic          clk, rst_n, valid_i, ready_o, valid_o, ready_i, busy_o;
  logic [DW-1:0] data_i;
  logic [CW-1:0] code_o;

  int n_vec, n_err;

  hamming_encoder_seq #(.DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .code_o  (code_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] code;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: data fills non-power-of-two slots, parity slots take the bits of the XOR of
  // set data positions so the total syndrome is zero; slot 0 makes overall parity even.
  function automatic logic [CW-1:0] model(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int s, di;
    c = '0; s = 0; di = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[di];
        if (d[di]) s = s ^ pos;
        di++;
      end
    end
    for (int i = 0; i < AW; i++) c[1 << i] = s[i];
    if (SECDED) c[0] = ^c;
    return c;
  endfunction

  function automatic int syndrome(input logic [CW-1:0] c);
    int s;
    s = 0;
    for (int j = 1; j < CW; j++) if (c[j]) s = s ^ j;
    return s;
  endfunction

  // Called at the negedge just after the accept edge.
  task automatic wait_out(input string name, input logic [CW-1:0] exp);
    int cyc;
    cyc = 0;
    while (!valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, LAT);
    check({name, " code"}, code_o, exp);
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic send(input string name, input logic [DW-1:0] d, input logic [CW-1:0] exp);
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = ~d;
    wait_out(name, exp);
  endtask

  vec_t tbl[4];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] held, e;
  int rcv;
  bit rose;

  initial begin
    n_vec = 0; n_err = 0; rcv = 0;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    tbl[0] = '{4'h1, SECDED ? 8'h0F : 8'h0E};
    tbl[1] = '{4'hF, SECDED ? 8'hFF : 8'hFE};
    tbl[2] = '{4'hB, 8'hAA};
    tbl[3] = '{4'h0, 8'h00};

    #3;
    check("reset valid_o", valid_o, 0);
    check("reset ready_o", ready_o, 0);
    check("reset code_o", code_o, 0);
    check("reset busy_o", busy_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release ready_o", ready_o, 1);
    @(negedge clk);

    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send($sformatf("tbl[%0d]", i), tbl[i].data, tbl[i].code);
      @(negedge clk);
      check($sformatf("tbl[%0d] valid drop", i), valid_o, 0);
      check($sformatf("tbl[%0d] idle", i), ready_o, 1);
    end

    // Backpressure: output must hold and a pending word must wait.
    ready_i = 1'b0;
    send("bp", 4'hB, 8'hAA);
    held = code_o;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      data_i  = 4'h5;
      @(negedge clk);
      check("bp hold valid_o", valid_o, 1);
      check("bp hold code_o", code_o, held);
      check("bp hold ready_o", ready_o, 0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp release valid_o", valid_o, 0);
    check("bp release ready_o", ready_o, 1);
    check("bp release code kept", code_o, held);
    @(negedge clk);
    check("bp accept busy_o", busy_o, 1);
    valid_i = 1'b0;
    wait_out("bp next", model(4'h5));
    @(negedge clk);

    // Abort in the second CALC cycle.
    valid_i = 1'b1;
    data_i  = 4'hF;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort valid_o", valid_o, 0);
    check("abort busy_o", busy_o, 0);
    check("abort code_o", code_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) rose = 1'b1;
    end
    check("abort no output", rose, 0);
    check("abort idle", ready_o, 1);
    send("after abort", 4'h1, SECDED ? 8'h0F : 8'h0E);
    @(negedge clk);

    // Randomized traffic; a word is logged exactly when the handshake completes.
    fork
      begin : drv
        int sent, cyc;
        sent = 0; cyc = 0;
        while (sent < N_RAND && cyc < LIMIT) begin
          @(negedge clk);
          cyc++;
          valid_i = ($urandom_range(3) != 0);
          data_i  = DW'($urandom);
          if (valid_i && ready_o) begin
            exp_q.push_back(model(data_i));
            sent++;
          end
        end
        @(negedge clk);
        valid_i = 1'b0;
      end
      begin : mon
        int cyc;
        cyc = 0;
        while (rcv < N_RAND && cyc < LIMIT) begin
          @(negedge clk);
          cyc++;
          ready_i = 1'($urandom_range(1));
          if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL rand extra word: got %0h, expected no word", code_o);
            end else begin
              e = exp_q.pop_front();
              check("rand code", code_o, e);
              check("rand syndrome", syndrome(code_o), 0);
              if (SECDED) check("rand overall parity", ^code_o, 0);
            end
            rcv++;
          end
        end
      end
    join
    check("rand words received", rcv, N_RAND);
    check("rand words pending", exp_q.size(), 0);
    ready_i = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o) rose = 1'b1;
    end
    check("rand no duplicate", rose, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
